id_ex_alu_stage: RTL and testbench
==================================

Name: id_ex_alu_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the 32-bit ALU.
- Captures decoded operands and control from the decode stage and selects operand B (register or immediate).
- Generates the ALU's 3-bit alu_control from ALUOp/funct.
- Presents everything registered to EX through a valid/ready handshake, with a 2-entry skid buffer so backpressure never drops an instruction.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_ADDR_W, 5, register-file address width

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  decode stage presents an instruction
- in_ready  output  1  stage can accept this cycle
- flush  input  1  squash all held instructions (branch mispredict)
- rs_data  input  DATA_W  register operand A
- rt_data  input  DATA_W  register operand B
- imm  input  DATA_W  already-extended immediate
- alu_src  input  1  1 = operand B is imm
- alu_op  input  2  main-decoder ALUOp
- funct  input  6  instruction funct field
- rt_addr, rd_addr  input  REG_ADDR_W  candidate destinations
- reg_dst  input  1  1 = destination is rd_addr
- ctl_in  input  5  {branch, mem_read, mem_write, mem_to_reg, reg_write}
- out_valid  output  1  EX-side entry valid
- out_ready  input  1  EX consumes this cycle
- alu_a  output  DATA_W  ALU operand a
- alu_b  output  DATA_W  ALU operand b
- alu_control  output  3  ALU operation code
- store_data  output  DATA_W  rt_data passthrough for sw
- dest_addr  output  REG_ADDR_W  selected destination register
- ctl_out  output  5  ctl_in passthrough
- illegal  output  1  unsupported funct under R-type

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. rst_n low clears both entry valids and all output data/control to 0; in_ready = 1 after reset.
- Storage: main entry drives the outputs; a skid entry absorbs one extra instruction.
- in_ready = NOT skid_valid, a combinational function of the register only. It never depends on out_ready.
- Accept: when in_valid && in_ready. If the main entry is empty, or is being consumed this cycle, the input loads main; otherwise it loads skid.
- Consume: when out_valid && out_ready. Skid moves into main if valid; main empties if skid is empty and nothing is accepted.
- Simultaneous accept and consume with skid empty: main reloads with the new instruction, giving full throughput of 1 per cycle.
- Latency: 1 cycle from acceptance to out_valid when the stage is empty.
- Output stability: while out_valid && !out_ready, every output holds stable.
- Flush: synchronous, highest priority. Next edge clears main and skid valids. An input offered in the flush cycle is discarded even if in_ready = 1.
- Data muxing, resolved at capture:
  - alu_a = rs_data
  - alu_b = alu_src ? imm : rt_data
  - dest_addr = reg_dst ? rd_addr : rt_addr
- ALU control decode, resolved at capture:
  - alu_op 00 -> 010 (add, lw/sw)
  - alu_op 01 -> 110 (sub, beq)
  - alu_op 11 -> 001 (or, ori)
  - alu_op 10 decodes funct:
    - 100000 -> 010 (add)
    - 100010 -> 110 (sub)
    - 100100 -> 000 (and)
    - 100101 -> 001 (or)
    - 100110 -> 011 (xor)
    - 100111 -> 100 (nor)
    - 101010 -> 111 (slt)
  - Any other funct -> alu_control 010, illegal = 1. illegal = 0 in every other case.
- Invalid entries: no arithmetic is performed here. Data fields of an invalid entry are don't-care, but they must not be X after reset.

Decomposition:
- Shared package (pipeline package) holds:
  - ALU code constants: ALU_AND = 000, ALU_OR = 001, ALU_ADD = 010, ALU_XOR = 011, ALU_NOR = 100, ALU_SUB = 110, ALU_SLT = 111
  - ALUOp constants
  - funct constants
  - Control-bundle bit indices for ctl_in/ctl_out
- One sub-module, alu_ctl_decode: combinational alu_op/funct -> {alu_control, illegal}. It is reused by the single-cycle datapath.
- Skid-buffer logic stays inline.

Test Plan:
- Reset then single R-type: rst_n low mid-stream clears everything. Then offer rs = 5, rt = 3, alu_op 10, funct 100010, reg_dst 1, rd = 9, with out_ready = 1 -> next cycle out_valid = 1, alu_a = 5, alu_b = 3, alu_control = 110, dest_addr = 9.
- Immediate path: lw with alu_op 00, alu_src 1, imm = 0xFFFFFFFC, rt_addr = 8, reg_dst 0 -> alu_b = 0xFFFFFFFC, alu_control = 010, dest_addr = 8, ctl_out = ctl_in.
- Backpressure: stream 4 instructions with out_ready = 0 -> in_ready drops after 2 accepted. Outputs stay on instruction 1 while stalled. Releasing out_ready yields instructions 1..4 in order, none lost or duplicated.
- Full throughput: in_valid = 1 and out_ready = 1 for 8 cycles -> 8 outputs on consecutive cycles; in_ready never drops.
- Flush with both entries full plus a new input offered -> next cycle out_valid = 0 and in_ready = 1; the offered input never appears on the outputs.
- Decode sweep: all 7 legal funct codes under alu_op 10 map to the listed alu_control values. funct = 000000 -> illegal = 1, alu_control = 010. alu_op 01 -> 110; alu_op 11 -> 001.

Source files
------------

// File: rtl/id_ex_alu_stage_pkg.sv
// Shared constants for the ID/EX stage and the ALU control decoder:
// ALU operation codes, main-decoder ALUOp values, R-type funct codes, and control-bundle bit positions.
package id_ex_alu_stage_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Bit positions within ctl_in/ctl_out = {branch, mem_read, mem_write, mem_to_reg, reg_write}
  localparam int CTL_W          = 5;
  localparam int CTL_REG_WRITE  = 0;
  localparam int CTL_MEM_TO_REG = 1;
  localparam int CTL_MEM_WRITE  = 2;
  localparam int CTL_MEM_READ   = 3;
  localparam int CTL_BRANCH     = 4;

endpackage

// File: rtl/id_ex_alu_stage_if.sv
// Decode-side inputs and EX-side outputs of the ID/EX stage.
// The master modport is the environment and the slave modport is the stage.
interface id_ex_alu_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [DATA_W-1:0]     rs_data;
  logic [DATA_W-1:0]     rt_data;
  logic [DATA_W-1:0]     imm;
  logic                  alu_src;
  logic [1:0]            alu_op;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  reg_dst;
  logic [4:0]            ctl_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     alu_a;
  logic [DATA_W-1:0]     alu_b;
  logic [2:0]            alu_control;
  logic [DATA_W-1:0]     store_data;
  logic [REG_ADDR_W-1:0] dest_addr;
  logic [4:0]            ctl_out;
  logic                  illegal;

  modport master (
    output in_valid, flush, rs_data, rt_data, imm, alu_src, alu_op, funct,
           rt_addr, rd_addr, reg_dst, ctl_in, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_control, store_data,
           dest_addr, ctl_out, illegal
  );

  modport slave (
    input  in_valid, flush, rs_data, rt_data, imm, alu_src, alu_op, funct,
           rt_addr, rd_addr, reg_dst, ctl_in, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_control, store_data,
           dest_addr, ctl_out, illegal
  );
endinterface

// File: rtl/id_ex_alu_stage_alu_ctl_decode.sv
// Combinational ALUOp/funct to 3-bit ALU control decoder.
// It is shared with the single-cycle datapath.
module alu_ctl_decode
  import id_ex_alu_stage_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       illegal_o
);

  // Map ALUOp, and funct for R-type, to the ALU operation; unknown R-type funct is flagged
  always_comb begin
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
    case (alu_op_i)
      ALUOP_MEM: alu_control_o = ALU_ADD;
      ALUOP_BEQ: alu_control_o = ALU_SUB;
      ALUOP_ORI: alu_control_o = ALU_OR;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: alu_control_o = ALU_ADD;
          FUNCT_SUB: alu_control_o = ALU_SUB;
          FUNCT_AND: alu_control_o = ALU_AND;
          FUNCT_OR:  alu_control_o = ALU_OR;
          FUNCT_XOR: alu_control_o = ALU_XOR;
          FUNCT_NOR: alu_control_o = ALU_NOR;
          FUNCT_SLT: alu_control_o = ALU_SLT;
          default: begin
            alu_control_o = ALU_ADD;
            illegal_o     = 1'b1;
          end
        endcase
      end
      default: begin
        alu_control_o = ALU_ADD;
        illegal_o     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_alu_stage.sv
// ID/EX pipeline register in front of the ALU.
// It resolves operand/destination muxing and ALU control at capture and uses a main entry plus a skid entry.
module id_ex_alu_stage
  import id_ex_alu_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_alu_stage_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0]     alu_a;
    logic [DATA_W-1:0]     alu_b;
    logic [DATA_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] dest_addr;
    logic [CTL_W-1:0]      ctl;
    logic [2:0]            alu_control;
    logic                  illegal;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, in_entry_s;
  logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic   in_ready_s, accept_s, consume_s;
  logic [2:0] dec_ctrl_s;
  logic       dec_illegal_s;

  alu_ctl_decode u_alu_ctl_decode (
    .alu_op_i      (bus.alu_op),
    .funct_i       (bus.funct),
    .alu_control_o (dec_ctrl_s),
    .illegal_o     (dec_illegal_s)
  );

  // in_ready depends only on the skid register, so it never waits on out_ready
  assign in_ready_s = ~skid_vld_q;
  assign accept_s   = bus.in_valid & in_ready_s;
  assign consume_s  = main_vld_q & bus.out_ready;

  // Build the entry as it will be seen by EX
  always_comb begin
    in_entry_s.alu_a       = bus.rs_data;
    in_entry_s.alu_b       = bus.alu_src ? bus.imm : bus.rt_data;
    in_entry_s.store_data  = bus.rt_data;
    in_entry_s.dest_addr   = bus.reg_dst ? bus.rd_addr : bus.rt_addr;
    in_entry_s.ctl         = bus.ctl_in;
    in_entry_s.alu_control = dec_ctrl_s;
    in_entry_s.illegal     = dec_illegal_s;
  end

  // Main/skid next state; flush wins over everything and drops any offered input
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (bus.flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (consume_s) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (accept_s) begin
        main_d = in_entry_s;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept_s) begin
      if (!main_vld_q) begin
        main_d     = in_entry_s;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = in_entry_s;
        skid_vld_d = 1'b1;
      end
    end else begin
      main_vld_d = main_vld_q;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = main_vld_q;
  assign bus.alu_a       = main_q.alu_a;
  assign bus.alu_b       = main_q.alu_b;
  assign bus.store_data  = main_q.store_data;
  assign bus.dest_addr   = main_q.dest_addr;
  assign bus.ctl_out     = main_q.ctl;
  assign bus.alu_control = main_q.alu_control;
  assign bus.illegal     = main_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_stage.sv
// Directed bench for id_ex_alu_stage: a table of single-instruction vectors,
// followed by reset, backpressure, throughput and flush sequences.
module tb_id_ex_alu_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  id_ex_alu_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

  id_ex_alu_stage #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        reg_dst;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [4:0]  ctl;
    logic [31:0] exp_b;
    logic [2:0]  exp_ctrl;
    logic        exp_ill;
    logic [4:0]  exp_dest;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                              input logic alu_src, input logic [1:0] alu_op, input logic [5:0] funct,
                              input logic reg_dst, input logic [4:0] rt_addr, input logic [4:0] rd_addr,
                              input logic [4:0] ctl, input logic [31:0] exp_b, input logic [2:0] exp_ctrl,
                              input logic exp_ill, input logic [4:0] exp_dest);
    vec_t v;
    v.rs = rs; v.rt = rt; v.imm = imm; v.alu_src = alu_src; v.alu_op = alu_op;
    v.funct = funct; v.reg_dst = reg_dst; v.rt_addr = rt_addr; v.rd_addr = rd_addr;
    v.ctl = ctl; v.exp_b = exp_b; v.exp_ctrl = exp_ctrl; v.exp_ill = exp_ill; v.exp_dest = exp_dest;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus.rs_data = 32'd0; bus.rt_data = 32'd0; bus.imm = 32'd0;
    bus.alu_src = 1'b0; bus.alu_op = 2'b00; bus.funct = 6'd0;
    bus.rt_addr = 5'd0; bus.rd_addr = 5'd0; bus.reg_dst = 1'b0; bus.ctl_in = 5'd0;
  endtask

  // Streams n instructions (alu_a = base + k), consuming when cyc >= ready_from; checks order
  task automatic stream(input int n, input logic [31:0] base, input int ready_from, input string tag);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bus.alu_op = 2'b00; bus.alu_src = 1'b0; bus.flush = 1'b0;
    while (got < n && cyc < 100) begin
      bus.in_valid  = (sent < n);
      bus.rs_data   = base + 32'(sent);
      bus.out_ready = (cyc >= ready_from);
      #1;
      if (ready_from > 0 && cyc >= 2 && cyc < ready_from) begin
        check({tag, " stall in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, " stall alu_a"}, bus.alu_a, base);
      end
      if (ready_from == 0 && sent < n)
        check({tag, " in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      if (bus.out_valid && bus.out_ready) begin
        check({tag, " order"}, bus.alu_a, base + 32'(got));
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
      cyc++;
    end
    check({tag, " all received"}, 32'(got), 32'(n));
    if (ready_from == 0) check({tag, " cycles"}, 32'(cyc), 32'(n + 1));
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check({tag, " drained"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = mk(32'd5, 32'd3, 32'd0, 1'b0, 2'b10, 6'b100010, 1'b1, 5'd3, 5'd9, 5'b00001,
                  32'd3, 3'b110, 1'b0, 5'd9);
    vecs[1]  = mk(32'h1000, 32'h77, 32'hFFFF_FFFC, 1'b1, 2'b00, 6'b000000, 1'b0, 5'd8, 5'd17, 5'b01011,
                  32'hFFFF_FFFC, 3'b010, 1'b0, 5'd8);
    vecs[2]  = mk(32'd1, 32'd2, 32'd99, 1'b0, 2'b10, 6'b100000, 1'b1, 5'd2, 5'd4, 5'b00001,
                  32'd2, 3'b010, 1'b0, 5'd4);
    vecs[3]  = mk(32'hF0F0, 32'h0FF0, 32'd0, 1'b0, 2'b10, 6'b100100, 1'b1, 5'd5, 5'd6, 5'b00001,
                  32'h0FF0, 3'b000, 1'b0, 5'd6);
    vecs[4]  = mk(32'd11, 32'd12, 32'd0, 1'b0, 2'b10, 6'b100101, 1'b1, 5'd7, 5'd10, 5'b00001,
                  32'd12, 3'b001, 1'b0, 5'd10);
    vecs[5]  = mk(32'd13, 32'd14, 32'd0, 1'b0, 2'b10, 6'b100110, 1'b1, 5'd11, 5'd12, 5'b00001,
                  32'd14, 3'b011, 1'b0, 5'd12);
    vecs[6]  = mk(32'd15, 32'd16, 32'd0, 1'b0, 2'b10, 6'b100111, 1'b1, 5'd13, 5'd14, 5'b00001,
                  32'd16, 3'b100, 1'b0, 5'd14);
    vecs[7]  = mk(32'd17, 32'd18, 32'd0, 1'b0, 2'b10, 6'b101010, 1'b1, 5'd15, 5'd31, 5'b00001,
                  32'd18, 3'b111, 1'b0, 5'd31);
    vecs[8]  = mk(32'd19, 32'd20, 32'd0, 1'b0, 2'b10, 6'b000000, 1'b1, 5'd16, 5'd18, 5'b00001,
                  32'd20, 3'b010, 1'b1, 5'd18);
    vecs[9]  = mk(32'd21, 32'd22, 32'd8, 1'b0, 2'b01, 6'b100100, 1'b0, 5'd19, 5'd20, 5'b10000,
                  32'd22, 3'b110, 1'b0, 5'd19);
    vecs[10] = mk(32'd23, 32'd24, 32'h00FF, 1'b1, 2'b11, 6'b101010, 1'b0, 5'd21, 5'd22, 5'b00001,
                  32'h00FF, 3'b001, 1'b0, 5'd21);
    vecs[11] = mk(32'd25, 32'hDEAD_BEEF, 32'd4, 1'b1, 2'b00, 6'b000000, 1'b0, 5'd23, 5'd24, 5'b00100,
                  32'd4, 3'b010, 1'b0, 5'd23);

    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset alu_a", bus.alu_a, 32'd0);
    check("reset ctl_out", {27'd0, bus.ctl_out}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Mid-stream reset with both entries loaded
    bus.in_valid = 1'b1; bus.rs_data = 32'hAAAA; bus.alu_op = 2'b01;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst alu_a", bus.alu_a, 32'd0);
    check("midrst alu_control", {29'd0, bus.alu_control}, 32'd0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      bus.rs_data = vecs[i].rs; bus.rt_data = vecs[i].rt; bus.imm = vecs[i].imm;
      bus.alu_src = vecs[i].alu_src; bus.alu_op = vecs[i].alu_op; bus.funct = vecs[i].funct;
      bus.reg_dst = vecs[i].reg_dst; bus.rt_addr = vecs[i].rt_addr; bus.rd_addr = vecs[i].rd_addr;
      bus.ctl_in = vecs[i].ctl; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check($sformatf("v%0d out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("v%0d alu_a", i), bus.alu_a, vecs[i].rs);
      check($sformatf("v%0d alu_b", i), bus.alu_b, vecs[i].exp_b);
      check($sformatf("v%0d alu_control", i), {29'd0, bus.alu_control}, {29'd0, vecs[i].exp_ctrl});
      check($sformatf("v%0d illegal", i), {31'd0, bus.illegal}, {31'd0, vecs[i].exp_ill});
      check($sformatf("v%0d dest_addr", i), {27'd0, bus.dest_addr}, {27'd0, vecs[i].exp_dest});
      check($sformatf("v%0d store_data", i), bus.store_data, vecs[i].rt);
      check($sformatf("v%0d ctl_out", i), {27'd0, bus.ctl_out}, {27'd0, vecs[i].ctl});
      tick();
      check($sformatf("v%0d consumed", i), {31'd0, bus.out_valid}, 32'd0);
    end

    stream(4, 32'h100, 6, "backpressure");
    stream(8, 32'h200, 0, "throughput");

    // Flush with both entries full and a third instruction offered
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.rs_data = 32'h301;
    tick();
    bus.rs_data = 32'h302;
    tick();
    check("flush pre in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.rs_data = 32'h303; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    check("flush full out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush full in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    check("flush full stays empty", {31'd0, bus.out_valid}, 32'd0);

    // Flush while in_ready=1: the offered input is still dropped
    bus.in_valid = 1'b1; bus.rs_data = 32'h304; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("flush empty out_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("flush empty stays empty", {31'd0, bus.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
